sobel_frame_sequencer: RTL and testbench

- Frame-level controller for the Sobel edge_detection compute core.
- The CPU configures it through a custom-instruction port. It then accepts a raster-order 8-bit grayscale pixel stream and builds 3x3 windows with two line buffers.
- For each interior pixel it runs the core's two-phase valueA/valueB transaction and streams the edge bytes out.
- It sits between the camera/DMA pixel stream, the CPU custom-instruction bus and one shared edge_detection instance.

---
 rtl/sobel_frame_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer
// Frame-level controller for a shared Sobel edge_detection core. The CPU
// programs the frame size and threshold through the custom-instruction port,
// then raster-order pixels stream in. Two line buffers plus a 3x3 register
// window produce one window per interior pixel. Each window is handed to the
// core as a two-phase transaction, and the edge bytes stream out.
module sobel_frame_sequencer #(
    parameter logic [7:0] customInstructionId = 8'h00,
    parameter int         MAX_WIDTH           = 640,
    parameter int         WIDTH_BITS          = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic        ciDone,
    output logic [31:0] ciResult,
    input  logic [7:0]  pixIn,
    input  logic        pixValid,
    output logic        pixReady,
    output logic        sobStart,
    output logic [31:0] sobValueA,
    output logic [31:0] sobValueB,
    input  logic        sobDone,
    input  logic [31:0] sobResult,
    output logic [7:0]  edgeOut,
    output logic        edgeValid,
    input  logic        edgeReady,
    output logic        busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FILL   = 3'd1;
    localparam logic [2:0] ACCEPT = 3'd2;
    localparam logic [2:0] PH1    = 3'd3;
    localparam logic [2:0] PH2    = 3'd4;
    localparam logic [2:0] EMIT   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam int                    AREA_W = 2 * WIDTH_BITS;
    localparam logic [WIDTH_BITS:0]   MAX_W  = (WIDTH_BITS + 1)'(MAX_WIDTH);
    localparam logic [WIDTH_BITS-1:0] ONE    = WIDTH_BITS'(1);
    localparam logic [WIDTH_BITS-1:0] TWO    = WIDTH_BITS'(2);
    localparam logic [WIDTH_BITS-1:0] THREE  = WIDTH_BITS'(3);

    // Number of interior pixels (= edge outputs) of a w x h frame.
    function automatic logic [AREA_W-1:0] frame_area(input logic [WIDTH_BITS-1:0] w,
                                                     input logic [WIDTH_BITS-1:0] h);
        logic [AREA_W-1:0] iw;
        logic [AREA_W-1:0] ih;
        iw = AREA_W'(w - TWO);
        ih = AREA_W'(h - TWO);
        return iw * ih;
    endfunction

    // A frame needs at least one interior pixel and must fit the line buffers.
    function automatic logic cfg_invalid(input logic [WIDTH_BITS-1:0] w,
                                         input logic [WIDTH_BITS-1:0] h);
        return (w < THREE) || (h < THREE) || ({1'b0, w} > MAX_W);
    endfunction

    // Control state
    logic [2:0]            state;
    logic                  issued;
    logic                  err;
    logic [15:0]           out_count;
    logic [WIDTH_BITS-1:0] width_reg;
    logic [WIDTH_BITS-1:0] height_reg;
    logic [7:0]            threshold;
    logic [WIDTH_BITS-1:0] frame_w;
    logic [7:0]            frame_thr;
    logic [AREA_W-1:0]     frame_total;
    logic [WIDTH_BITS-1:0] col;
    logic [WIDTH_BITS-1:0] row;
    logic [7:0]            edge_q;
    logic                  ci_done_p1;
    logic [31:0]           ci_result_p1;

    // Pixel storage: two line buffers and the 3x3 window, p0 top-left .. p8 bottom-right
    logic [7:0] line_buf0 [0:MAX_WIDTH-1];
    logic [7:0] line_buf1 [0:MAX_WIDTH-1];
    logic [7:0] win [0:8];
    logic [7:0] top_px;
    logic [7:0] mid_px;

    // Decode and helpers
    logic                  ci_hit;
    logic [2:0]            ci_sel;
    logic                  busy_int;
    logic                  start_req;
    logic                  pix_fire;
    logic                  col_last;
    logic [WIDTH_BITS-1:0] col_nxt;
    logic [WIDTH_BITS-1:0] row_nxt;
    logic [15:0]           out_next;
    logic                  frame_last;
    logic [31:0]           status_word;
    logic                  unused_bits;

    assign ci_hit    = ciStart && (ciN == customInstructionId);
    assign ci_sel    = ciValueA[2:0];
    assign busy_int  = (state == FILL) || (state == ACCEPT) || (state == PH1) ||
                       (state == PH2) || (state == EMIT);
    assign start_req = ci_hit && (ci_sel == 3'd3) && !busy_int;

    assign pixReady  = (state == FILL) || (state == ACCEPT);
    assign pix_fire  = pixValid && pixReady;

    assign col_last  = (col == frame_w - ONE);
    assign col_nxt   = col_last ? '0 : col + ONE;
    assign row_nxt   = col_last ? row + ONE : row;

    assign out_next    = out_count + 16'd1;
    assign frame_last  = (32'(out_next) == 32'(frame_total));
    assign status_word = {busy_int, err, 14'd0, out_count};

    assign top_px = line_buf0[col];
    assign mid_px = line_buf1[col];

    assign sobStart  = ((state == PH1) || (state == PH2)) && !issued;
    assign edgeValid = (state == EMIT);
    assign edgeOut   = edge_q;
    assign busy      = busy_int;
    assign ciDone    = ci_done_p1;
    assign ciResult  = ci_result_p1;

    assign unused_bits = ^{ciValueA[31:3], ciValueB[31:WIDTH_BITS], sobResult[31:8]};

    // Core operands are driven for the whole phase so they stay stable until sobDone
    always_comb begin
        sobValueA = 32'd0;
        sobValueB = 32'd0;
        case (state)
            PH1: sobValueA = {win[3], win[2], win[1], win[0]};
            PH2: begin
                sobValueA = {win[7], win[6], win[5], win[4]};
                sobValueB = {8'h00, frame_thr, win[8], 8'h01};
            end
            default: ;
        endcase
    end

    // Custom-instruction response: one-cycle pulse, result zero unless a status read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ci_done_p1   <= 1'b0;
            ci_result_p1 <= 32'd0;
        end else begin
            ci_done_p1   <= ci_hit;
            ci_result_p1 <= (ci_hit && (ci_sel == 3'd4)) ? status_word : 32'd0;
        end
    end

    // Configuration registers; writes land any time, frames use the copy latched at start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            width_reg  <= '0;
            height_reg <= '0;
            threshold  <= 8'd128;
        end else if (ci_hit) begin
            case (ci_sel)
                3'd0:    width_reg  <= ciValueB[WIDTH_BITS-1:0];
                3'd1:    height_reg <= ciValueB[WIDTH_BITS-1:0];
                3'd2:    threshold  <= ciValueB[7:0];
                default: ;
            endcase
        end
    end

    // Frame sequencing: fill, per-pixel accept, two core phases, emit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            issued      <= 1'b0;
            err         <= 1'b0;
            out_count   <= 16'd0;
            frame_w     <= '0;
            frame_thr   <= 8'd0;
            frame_total <= '0;
            col         <= '0;
            row         <= '0;
            edge_q      <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start_req) begin
                        if (cfg_invalid(width_reg, height_reg)) begin
                            err <= 1'b1;
                        end else begin
                            err         <= 1'b0;
                            out_count   <= 16'd0;
                            frame_w     <= width_reg;
                            frame_thr   <= threshold;
                            frame_total <= frame_area(width_reg, height_reg);
                            col         <= '0;
                            row         <= '0;
                            issued      <= 1'b0;
                            state       <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (pix_fire) begin
                        col <= col_nxt;
                        row <= row_nxt;
                        if ((row == TWO) && (col == TWO)) state <= PH1;
                    end
                end
                ACCEPT: begin
                    if (pix_fire) begin
                        col <= col_nxt;
                        row <= row_nxt;
                        // columns 0 and 1 only refill the window after a row wrap
                        if (col >= TWO) state <= PH1;
                    end
                end
                PH1: begin
                    if (sobDone) begin
                        issued <= 1'b0;
                        state  <= PH2;
                    end else if (sobStart) begin
                        issued <= 1'b1;
                    end
                end
                PH2: begin
                    if (sobDone) begin
                        issued <= 1'b0;
                        edge_q <= sobResult[7:0];
                        state  <= EMIT;
                    end else if (sobStart) begin
                        issued <= 1'b1;
                    end
                end
                EMIT: begin
                    if (edgeReady) begin
                        out_count <= out_next;
                        state     <= frame_last ? DONE : ACCEPT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffers and window shift: each accepted pixel pushes its column up one row
    always_ff @(posedge clock) begin
        if (pix_fire) begin
            line_buf0[col] <= mid_px;
            line_buf1[col] <= pixIn;
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= top_px;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= mid_px;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= pixIn;
        end
    end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: random frames checked against an image-level
// reference model, plus directed configuration, backpressure, error and reset cases.
module tb_sobel_frame_sequencer;

    localparam logic [7:0] CI_ID = 8'h00;

    logic        clock;
    logic        reset;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic [7:0]  pixIn;
    logic        pixValid;
    logic        pixReady;
    logic        sobStart;
    logic [31:0] sobValueA;
    logic [31:0] sobValueB;
    logic        sobDone;
    logic [31:0] sobResult;
    logic [7:0]  edgeOut;
    logic        edgeValid;
    logic        edgeReady;
    logic        busy;

    sobel_frame_sequencer #(
        .customInstructionId(CI_ID),
        .MAX_WIDTH(640),
        .WIDTH_BITS(10)
    ) dut (
        .clock(clock), .reset(reset),
        .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone), .ciResult(ciResult),
        .pixIn(pixIn), .pixValid(pixValid), .pixReady(pixReady),
        .sobStart(sobStart), .sobValueA(sobValueA), .sobValueB(sobValueB),
        .sobDone(sobDone), .sobResult(sobResult),
        .edgeOut(edgeOut), .edgeValid(edgeValid), .edgeReady(edgeReady),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Edge byte of a 3x3 neighbourhood: |Gx|+|Gy| saturated to 255, zeroed below threshold
    function automatic logic [7:0] edge_of(input int p [0:8], input int thr);
        int gx, gy, mag;
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        if (mag > 255) mag = 255;
        return (mag >= thr) ? 8'(mag) : 8'h00;
    endfunction

    // ---------------- edge_detection core model ----------------
    bit          comb_core = 1'b0;
    int          fixed_lat = 0;
    int          rem;
    logic [31:0] ph1_q;
    logic [7:0]  core_byte;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem <= 0;
        end else begin
            if (sobStart && (sobValueB[0] == 1'b0)) ph1_q <= sobValueA;
            if (sobStart && !comb_core)
                rem <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
            else if (rem > 0)
                rem <= rem - 1;
        end
    end

    always_comb begin
        int p [0:8];
        p[0] = int'(ph1_q[7:0]);
        p[1] = int'(ph1_q[15:8]);
        p[2] = int'(ph1_q[23:16]);
        p[3] = int'(ph1_q[31:24]);
        p[4] = int'(sobValueA[7:0]);
        p[5] = int'(sobValueA[15:8]);
        p[6] = int'(sobValueA[23:16]);
        p[7] = int'(sobValueA[31:24]);
        p[8] = int'(sobValueB[15:8]);
        core_byte = edge_of(p, int'(sobValueB[23:16]));
    end

    assign sobDone   = comb_core ? sobStart : (rem == 1);
    assign sobResult = {24'hA5C3E1, core_byte};

    // ---------------- reference model and monitor ----------------
    int          img [0:15][0:15];
    logic [31:0] exp_a1 [$];
    logic [31:0] exp_a2 [$];
    logic [31:0] exp_b2 [$];
    logic [7:0]  exp_edge [$];
    logic [31:0] obs_a1 [$];
    logic [31:0] obs_a2 [$];
    logic [31:0] obs_b2 [$];
    int          sob_cnt = 0;
    bit          mon_ph = 1'b0;
    int          last_count = 0;

    task automatic load_expected(input int w, input int h, input int thr);
        exp_a1.delete(); exp_a2.delete(); exp_b2.delete(); exp_edge.delete();
        obs_a1.delete(); obs_a2.delete(); obs_b2.delete();
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= w - 2; c++) begin
                int p [0:8];
                int k;
                k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        p[k] = img[r + dr][c + dc];
                        k++;
                    end
                exp_a1.push_back({8'(p[3]), 8'(p[2]), 8'(p[1]), 8'(p[0])});
                exp_a2.push_back({8'(p[7]), 8'(p[6]), 8'(p[5]), 8'(p[4])});
                exp_b2.push_back({8'h00, 8'(thr), 8'(p[8]), 8'h01});
                exp_edge.push_back(edge_of(p, thr));
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            mon_ph <= 1'b0;
        end else begin
            if (sobStart) begin
                sob_cnt <= sob_cnt + 1;
                if (!mon_ph) begin
                    obs_a1.push_back(sobValueA);
                    if (exp_a1.size() == 0) check("ph1_extra", exp_a1.size(), 1);
                    else begin
                        check("ph1_A", sobValueA, exp_a1.pop_front());
                        check("ph1_B", sobValueB, 32'd0);
                    end
                end else begin
                    obs_a2.push_back(sobValueA);
                    obs_b2.push_back(sobValueB);
                    if (exp_a2.size() == 0) check("ph2_extra", exp_a2.size(), 1);
                    else begin
                        check("ph2_A", sobValueA, exp_a2.pop_front());
                        check("ph2_B", sobValueB, exp_b2.pop_front());
                    end
                end
                mon_ph <= !mon_ph;
            end
            if (edgeValid && edgeReady) begin
                if (exp_edge.size() == 0) check("edge_extra", exp_edge.size(), 1);
                else check("edge", {24'd0, edgeOut}, {24'd0, exp_edge.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic ci_op(input logic [2:0] sel, input logic [31:0] val, output logic [31:0] res);
        ciStart  = 1'b1;
        ciN      = CI_ID;
        ciValueA = {29'd0, sel};
        ciValueB = val;
        @(posedge clock); #1;
        ciStart = 1'b0;
        check("ci_done", ciDone, 1);
        res = ciResult;
    endtask

    task automatic feed_pixels(input int w, input int h, input bit gaps);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                bit acc;
                int waited;
                if (gaps && ($urandom_range(0, 3) == 0)) begin
                    pixValid = 1'b0;
                    @(posedge clock); #1;
                end
                pixIn    = 8'(img[r][c]);
                pixValid = 1'b1;
                acc      = 1'b0;
                waited   = 0;
                while (!acc) begin
                    @(negedge clock);
                    acc = pixReady;
                    @(posedge clock); #1;
                    waited++;
                    if (waited > 2000) begin
                        check("pix_timeout", waited, 0);
                        pixValid = 1'b0;
                        return;
                    end
                end
            end
        end
        pixValid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: hold off 10 cycles on the first edge then random
    task automatic consume(input int n, input int mode);
        int         got;
        int         guard;
        bit         bp_done;
        logic [7:0] e;
        int         s;
        got       = 0;
        guard     = 0;
        bp_done   = (mode != 2);
        edgeReady = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        while (got < n) begin
            @(negedge clock);
            if (edgeValid && !bp_done) begin
                e = edgeOut;
                s = sob_cnt;
                repeat (10) begin
                    @(posedge clock); #1;
                    edgeReady = 1'b0;
                    @(negedge clock);
                    check("bp_edge_hold", {24'd0, edgeOut}, {24'd0, e});
                    check("bp_pixready", pixReady, 0);
                    check("bp_valid", edgeValid, 1);
                end
                check("bp_no_sobstart", sob_cnt, s);
                bp_done = 1'b1;
            end
            if (edgeValid && edgeReady) got++;
            @(posedge clock); #1;
            if (!bp_done) edgeReady = 1'b0;
            else if (mode == 0) edgeReady = 1'b1;
            else edgeReady = ($urandom_range(0, 2) != 0);
            guard++;
            if (guard > 5000) begin
                check("edge_timeout", got, n);
                break;
            end
        end
        edgeReady = 1'b1;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clock);
            g++;
        end
        check("idle_reached", busy, 0);
        @(posedge clock); #1;
    endtask

    task automatic start_frame(input int w, input int h, input int thr);
        logic [31:0] res;
        load_expected(w, h, thr);
        ci_op(3'd0, w, res);
        check("ci_res_w", res, 0);
        ci_op(3'd1, h, res);
        ci_op(3'd2, thr, res);
        ci_op(3'd3, 0, res);
        check("ci_res_start", res, 0);
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_frame(input int n);
        logic [31:0] res;
        wait_idle();
        check("left_ph1", exp_a1.size(), 0);
        check("left_edges", exp_edge.size(), 0);
        ci_op(3'd4, 0, res);
        check("status_after_frame", res, {16'd0, 16'(n)});
        last_count = n;
    endtask

    task automatic run_frame(input int w, input int h, input int thr, input int cmode, input bit gaps);
        int n;
        n = (w - 2) * (h - 2);
        start_frame(w, h, thr);
        fork
            feed_pixels(w, h, gaps);
            consume(n, cmode);
        join
        finish_frame(n);
    endtask

    task automatic rand_image(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = int'($urandom_range(0, 255));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [31:0] v;
        int          seen;
        int          g;
        bit          hit;

        reset = 1'b0; ciStart = 1'b0; ciN = 8'h00; ciValueA = 0; ciValueB = 0;
        pixIn = 8'h00; pixValid = 1'b0; edgeReady = 1'b0;
        #12;
        check("rst_ciDone", ciDone, 0);
        check("rst_ciResult", ciResult, 0);
        check("rst_pixReady", pixReady, 0);
        check("rst_sobStart", sobStart, 0);
        check("rst_sobValueA", sobValueA, 0);
        check("rst_sobValueB", sobValueB, 0);
        check("rst_edgeOut", {24'd0, edgeOut}, 0);
        check("rst_edgeValid", edgeValid, 0);
        check("rst_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Instruction addressed to another id is not answered
        ciStart = 1'b1; ciN = 8'h33; ciValueA = 32'd4; ciValueB = 0;
        @(posedge clock); #1;
        ciStart = 1'b0;
        check("foreign_ci_done", ciDone, 0);
        check("foreign_ci_result", ciResult, 0);

        // Config and status read, threshold 200 seen by the core
        ci_op(3'd2, 32'd200, res);
        check("thr_write_res", res, 0);
        ci_op(3'd4, 0, res);
        check("status_initial", res, 0);
        @(posedge clock); #1;
        check("ci_done_single_pulse", ciDone, 0);
        rand_image(3, 3);
        load_expected(3, 3, 200);
        ci_op(3'd0, 3, res);
        ci_op(3'd1, 3, res);
        ci_op(3'd3, 0, res);
        fork
            feed_pixels(3, 3, 1'b0);
            consume(1, 0);
        join
        finish_frame(1);
        v = (obs_b2.size() > 0) ? obs_b2[0] : 32'd0;
        check("thr_in_valueB", {24'd0, v[23:16]}, 32'hC8);

        // Fixed 3x3 frame, threshold 128
        img[0][0] = 200; img[0][1] = 102; img[0][2] = 103;
        img[1][0] = 244; img[1][1] = 155; img[1][2] = 166;
        img[2][0] = 70;  img[2][1] = 80;  img[2][2] = 90;
        comb_core = 1'b0;
        run_frame(3, 3, 128, 0, 1'b0);
        v = (obs_a1.size() > 0) ? obs_a1[0] : 32'd0;
        check("fixed_ph1_A", v, 32'hF46766C8);
        v = (obs_a2.size() > 0) ? obs_a2[0] : 32'd0;
        check("fixed_ph2_A", v, 32'h5046A69B);
        v = (obs_b2.size() > 0) ? obs_b2[0] : 32'd0;
        check("fixed_ph2_B", v, 32'h00805A01);

        // 5x4 ramp frame
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                img[r][c] = 10 * r + c;
        comb_core = 1'b1;
        run_frame(5, 4, 40, 1, 1'b1);
        check("ramp_windows", obs_a1.size(), 6);
        v = (obs_a1.size() > 2) ? obs_a1[2] : 32'hFFFFFFFF;
        check("ramp_w3_p0", {24'd0, v[7:0]}, 2);
        v = (obs_a2.size() > 2) ? obs_a2[2] : 32'hFFFFFFFF;
        check("ramp_w3_p4", {24'd0, v[7:0]}, 13);

        // Backpressure on the first edge
        comb_core = 1'b0;
        rand_image(6, 4);
        run_frame(6, 4, int'($urandom_range(0, 255)), 2, 1'b0);

        // Random frames, random core latency, random gaps and ready
        for (int i = 0; i < 5; i++) begin
            int w, h;
            w = int'($urandom_range(3, 10));
            h = int'($urandom_range(3, 6));
            comb_core = 1'($urandom_range(0, 1));
            rand_image(w, h);
            run_frame(w, h, int'($urandom_range(0, 255)), 1, 1'b1);
        end

        // Start and width write during a busy frame are ignored by that frame
        comb_core = 1'b0;
        rand_image(4, 4);
        start_frame(4, 4, 60);
        fork
            feed_pixels(4, 4, 1'b0);
            consume(4, 1);
            begin
                logic [31:0] r2;
                repeat (6) @(posedge clock);
                #1;
                ci_op(3'd0, 32'd9, r2);
                ci_op(3'd3, 0, r2);
                check("busy_start_res", r2, 0);
            end
        join
        finish_frame(4);

        // Invalid geometry sets err and stays idle; outCount kept
        ci_op(3'd0, 32'd2, res);
        ci_op(3'd1, 32'd5, res);
        ci_op(3'd3, 0, res);
        check("err_busy_w2", busy, 0);
        ci_op(3'd4, 0, res);
        check("status_err_w2", res, {2'b01, 14'd0, 16'(last_count)});
        ci_op(3'd0, 32'd641, res);
        ci_op(3'd1, 32'd3, res);
        ci_op(3'd3, 0, res);
        check("err_busy_w641", busy, 0);
        ci_op(3'd4, 0, res);
        check("status_err_w641", res, {2'b01, 14'd0, 16'(last_count)});

        // Valid frame clears err
        rand_image(3, 4);
        run_frame(3, 4, 10, 0, 1'b0);

        // Asynchronous reset while the core is working on phase 2
        comb_core = 1'b0;
        fixed_lat = 3;
        rand_image(3, 3);
        start_frame(3, 3, 77);
        edgeReady = 1'b1;
        feed_pixels(3, 3, 1'b0);
        g   = 0;
        hit = 1'b0;
        while (!hit && g < 100) begin
            @(negedge clock);
            if (sobStart && sobValueB[0]) hit = 1'b1;
            g++;
        end
        check("ph2_reached", hit, 1);
        reset = 1'b0;
        #1;
        check("arst_sobStart", sobStart, 0);
        check("arst_sobValueA", sobValueA, 0);
        check("arst_sobValueB", sobValueB, 0);
        check("arst_edgeValid", edgeValid, 0);
        check("arst_edgeOut", {24'd0, edgeOut}, 0);
        check("arst_busy", busy, 0);
        check("arst_pixReady", pixReady, 0);
        exp_a1.delete(); exp_a2.delete(); exp_b2.delete(); exp_edge.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        fixed_lat = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (edgeValid || sobStart || busy) seen++;
        end
        check("post_reset_quiet", seen, 0);
        @(posedge clock); #1;
        ci_op(3'd4, 0, res);
        check("status_after_reset", res, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
